// File: rtl/ekf_sched_pkg.sv
// Shared encodings for the EKF stage scheduler: one-hot stage codes, FSM states, error codes.
package ekf_sched_pkg;

  localparam logic [2:0] STAGE_IDLE = 3'b000;
  localparam logic [2:0] STAGE_PRD  = 3'b001;
  localparam logic [2:0] STAGE_NEW  = 3'b010;
  localparam logic [2:0] STAGE_UPD  = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } sched_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_FULL    = 2'b01;
  localparam logic [1:0] ERR_BADLK   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/sched_prio_arb.sv
// Fixed-priority one-hot picker over pending stage requests: PRD beats UPD beats NEW.
module sched_prio_arb
  import ekf_sched_pkg::*;
(
  input  logic [2:0] req,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = STAGE_IDLE;
    if (req[0])      gnt = STAGE_PRD;
    else if (req[2]) gnt = STAGE_UPD;
    else if (req[1]) gnt = STAGE_NEW;
  end

endmodule

// File: rtl/ekf_stage_scheduler.sv
// Front-end sequencer for the RSA: latches stage requests, validates, launches and commits them.
// Optional RUN watchdog is built in when EKF_SCHED_WDT_EN is defined.
module ekf_stage_scheduler
  import ekf_sched_pkg::*;
#(
  parameter int ROW_LEN    = 10,
  parameter int MAX_LM     = 500,
  parameter int CNT_DW     = 16,
  parameter int WDT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               sys_rst_n,
  input  logic [2:0]         host_val,
  input  logic [ROW_LEN-1:0] host_lk,
  output logic [2:0]         host_rdy,
  output logic [2:0]         stage_val,
  input  logic [2:0]         stage_rdy,
  input  logic [2:0]         stage_done,
  output logic [ROW_LEN-1:0] landmark_num,
  output logic [ROW_LEN-1:0] l_k,
  output logic               busy,
  output logic [2:0]         done_stage,
  output logic [CNT_DW-1:0]  last_cycles,
  output logic               err_val,
  output logic [1:0]         err_code
);

  localparam logic [ROW_LEN-1:0] LM_FULL = ROW_LEN'(MAX_LM);

  sched_state_t       state, state_nxt;
  logic [2:0]         pend, sel, pick, pend_clr;
  logic [ROW_LEN-1:0] upd_lk;
  logic [CNT_DW-1:0]  cnt;
  logic               take_sel, chk_ok, launch, commit, err_hit, wdt_hit;
  logic [1:0]         err_nxt;

  sched_prio_arb u_arb (
    .req (pend),
    .gnt (pick)
  );

  assign host_rdy = ~pend;
  assign busy     = (state != S_IDLE);

`ifdef EKF_SCHED_WDT_EN
  assign wdt_hit = (cnt == CNT_DW'(WDT_CYCLES - 1));
`else
  logic unused_wdt;
  assign unused_wdt = (WDT_CYCLES != 0);
  assign wdt_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Handshake: a transfer happens in the cycle where a valid bit and the matching ready bit are
  // both high; valid is held stable until then and the target may raise ready at any time.
  always_comb begin
    state_nxt  = state;
    stage_val  = STAGE_IDLE;
    done_stage = STAGE_IDLE;
    take_sel   = 1'b0;
    chk_ok     = 1'b0;
    launch     = 1'b0;
    commit     = 1'b0;
    err_hit    = 1'b0;
    err_nxt    = ERR_NONE;
    case (state)
      S_IDLE: begin
        if (pend != 3'b000) begin
          take_sel  = 1'b1;
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (sel == STAGE_NEW && landmark_num == LM_FULL) begin
          err_hit   = 1'b1;
          err_nxt   = ERR_FULL;
          state_nxt = S_IDLE;
        end else if (sel == STAGE_UPD && upd_lk >= landmark_num) begin
          err_hit   = 1'b1;
          err_nxt   = ERR_BADLK;
          state_nxt = S_IDLE;
        end else begin
          chk_ok    = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        stage_val = sel;
        if ((sel & stage_rdy) != 3'b000) begin
          launch    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if ((stage_done & sel) != 3'b000) begin
          state_nxt = S_DONE;
        end else if (wdt_hit) begin
          err_hit   = 1'b1;
          err_nxt   = ERR_TIMEOUT;
          state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        done_stage = sel;
        commit     = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A latch only sets while empty and only clears while full, so set and clear never collide.
  assign pend_clr = (commit || err_hit) ? sel : STAGE_IDLE;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend   <= 3'b000;
      upd_lk <= '0;
      sel    <= STAGE_IDLE;
    end else begin
      pend <= (pend & ~pend_clr) | (host_val & ~pend);
      if (host_val[2] && !pend[2]) upd_lk <= host_lk;
      if (take_sel) sel <= pick;
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt          <= '0;
      last_cycles  <= '0;
      landmark_num <= '0;
      l_k          <= '0;
      err_val      <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      if (launch) cnt <= '0;
      else if (state == S_RUN && cnt != {CNT_DW{1'b1}}) cnt <= cnt + 1'b1;
      if (chk_ok) begin
        if (sel == STAGE_NEW)      l_k <= landmark_num;
        else if (sel == STAGE_UPD) l_k <= upd_lk;
      end
      if (commit) begin
        last_cycles <= cnt;
        if (sel == STAGE_NEW && landmark_num != LM_FULL) landmark_num <= landmark_num + 1'b1;
      end
      err_val <= err_hit;
      if (err_hit) err_code <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ekf_stage_scheduler.sv
// Bench for ekf_stage_scheduler: vector table, corner sequences, then random episodes vs a stage-level model.
module tb_ekf_stage_scheduler;

  localparam int ROW_LEN    = 10;
  localparam int MAX_LM     = 8;
  localparam int CNT_DW     = 16;
  localparam int WDT_CYCLES = 16;

  logic               clk = 1'b0;
  logic               sys_rst_n;
  logic [2:0]         host_val, host_rdy, stage_val, stage_rdy, stage_done, done_stage;
  logic [ROW_LEN-1:0] host_lk, landmark_num, l_k;
  logic               busy, err_val;
  logic [1:0]         err_code;
  logic [CNT_DW-1:0]  last_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  // expected events: {is_err, stage[2:0], code[1:0], l_k[9:0]}
  logic [15:0] exp_q[$];
  int          m_lm;
  logic [9:0]  m_lk;

  typedef struct {
    logic [2:0]  req;
    logic [9:0]  lk;
    int          rdy_dly;
    int          run_len;
    logic [9:0]  exp_lm;
    logic [9:0]  exp_lk;
    logic [1:0]  exp_code;
    logic [15:0] exp_cyc;
  } vec_t;
  vec_t vecs[13];

  ekf_stage_scheduler #(
    .ROW_LEN(ROW_LEN), .MAX_LM(MAX_LM), .CNT_DW(CNT_DW), .WDT_CYCLES(WDT_CYCLES)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n),
    .host_val(host_val), .host_lk(host_lk), .host_rdy(host_rdy),
    .stage_val(stage_val), .stage_rdy(stage_rdy), .stage_done(stage_done),
    .landmark_num(landmark_num), .l_k(l_k), .busy(busy), .done_stage(done_stage),
    .last_cycles(last_cycles), .err_val(err_val), .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL global_timeout: got no end of test, expected end of test");
    $fatal(1, "simulation time limit");
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_host_rdy"}, host_rdy, 3'b111);
    check({tag, "_stage_val"}, stage_val, 0);
    check({tag, "_landmark_num"}, landmark_num, 0);
    check({tag, "_l_k"}, l_k, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done_stage"}, done_stage, 0);
    check({tag, "_last_cycles"}, last_cycles, 0);
    check({tag, "_err_val"}, err_val, 0);
    check({tag, "_err_code"}, err_code, 0);
  endtask

  // Requests captured together are served in priority order PRD, UPD, NEW.
  task automatic model_episode(input logic [2:0] req, input logic [9:0] lk);
    if (req[0]) exp_q.push_back({1'b0, 3'b001, 2'b00, m_lk});
    if (req[2]) begin
      if (int'(lk) >= m_lm) exp_q.push_back({1'b1, 3'b100, 2'b10, 10'd0});
      else begin
        m_lk = lk;
        exp_q.push_back({1'b0, 3'b100, 2'b00, lk});
      end
    end
    if (req[1]) begin
      if (m_lm == MAX_LM) exp_q.push_back({1'b1, 3'b010, 2'b01, 10'd0});
      else begin
        m_lk = 10'(m_lm);
        exp_q.push_back({1'b0, 3'b010, 2'b00, 10'(m_lm)});
        m_lm++;
      end
    end
  endtask

  // Acts as the RSA and checks every launch, error and commit against exp_q.
  task automatic serve(input int rdy_dly, input int run_len, input int repost);
    int         phase, wcnt, rcnt, repost_left;
    logic [2:0] cur;
    logic [15:0] ev;
    bit         lc_pending, reposted, finished;
    phase = 0; wcnt = 0; rcnt = 0; repost_left = 0; cur = 3'b000;
    lc_pending = 0; reposted = 0; finished = 0;
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      @(negedge clk);
      host_val   = 3'b000;
      stage_rdy  = 3'b000;
      stage_done = 3'($urandom_range(0, 7));
      if (lc_pending) begin
        check("last_cycles", last_cycles, run_len);
        lc_pending = 0;
      end
      if (err_val) begin
        check("err_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          ev = exp_q.pop_front();
          check("err_kind", 1, ev[15]);
          check("err_code", err_code, ev[11:10]);
        end
      end
      if (done_stage != 3'b000) begin
        check("done_stage", done_stage, cur);
        lc_pending = 1;
        if (!reposted && repost > 0) begin
          reposted    = 1;
          repost_left = repost;
          check("rdy_low_in_done", host_rdy & cur, 0);
        end
      end
      if (repost_left > 0) begin
        host_val = cur;
        repost_left--;
      end
      if (phase == 2) begin
        check("stage_val_low_in_run", stage_val, 0);
        rcnt++;
        if (rcnt == run_len) begin
          stage_done = cur;
          phase = 0;
        end else stage_done = stage_done & ~cur;
      end else begin
        if (phase == 0 && stage_val != 3'b000) begin
          check("launch_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            ev = exp_q.pop_front();
            check("launch_kind", ev[15], 0);
            check("stage_val", stage_val, ev[14:12]);
            check("l_k_at_issue", l_k, ev[9:0]);
          end
          cur = stage_val; phase = 1; wcnt = 0;
        end else if (phase == 1) begin
          check("stage_val_hold", stage_val, cur);
        end
        if (phase == 1) begin
          if (wcnt == rdy_dly) begin
            stage_rdy = cur; phase = 2; rcnt = 0;
          end else begin
            stage_rdy = 3'($urandom_range(0, 7)) & ~cur;
            wcnt++;
          end
        end else if (exp_q.size() == 0 && !lc_pending && repost_left == 0 &&
                     !busy && host_rdy == 3'b111) begin
          finished = 1;
        end
      end
    end
    check("episode_finished", finished, 1);
    exp_q.delete();
    host_val = 3'b000; stage_rdy = 3'b000; stage_done = 3'b000;
  endtask

  task automatic episode(input logic [2:0] req, input logic [9:0] lk, input int rdy_dly,
                         input int run_len, input int repost);
    @(negedge clk);
    host_val = req;
    host_lk  = lk;
    model_episode(req, lk);
    if (repost == 2) model_episode(req, lk);
    serve(rdy_dly, run_len, repost);
  endtask

  task automatic launch_prd();
    int w;
    @(negedge clk); host_val = 3'b001;
    @(negedge clk); host_val = 3'b000;
    w = 0;
    while (stage_val == 3'b000 && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("prd_launch", stage_val, 3'b001);
    check("prd_l_k", l_k, m_lk);
    stage_rdy = 3'b001;
  endtask

  initial begin
    //                req     lk     rdy run  lm     l_k    code   cycles
    vecs[0]  = '{3'b001, 10'd0, 2, 5,  10'd0, 10'd0, 2'b00, 16'd5};
    vecs[1]  = '{3'b010, 10'd0, 0, 1,  10'd1, 10'd0, 2'b00, 16'd1};
    vecs[2]  = '{3'b010, 10'd0, 1, 3,  10'd2, 10'd1, 2'b00, 16'd3};
    vecs[3]  = '{3'b100, 10'd5, 0, 4,  10'd2, 10'd1, 2'b10, 16'd3};
    vecs[4]  = '{3'b111, 10'd1, 0, 2,  10'd3, 10'd2, 2'b10, 16'd2};
    vecs[5]  = '{3'b010, 10'd0, 3, 1,  10'd4, 10'd3, 2'b10, 16'd1};
    vecs[6]  = '{3'b100, 10'd3, 0, 6,  10'd4, 10'd3, 2'b10, 16'd6};
    vecs[7]  = '{3'b010, 10'd0, 0, 2,  10'd5, 10'd4, 2'b10, 16'd2};
    vecs[8]  = '{3'b010, 10'd0, 0, 1,  10'd6, 10'd5, 2'b10, 16'd1};
    vecs[9]  = '{3'b010, 10'd0, 0, 1,  10'd7, 10'd6, 2'b10, 16'd1};
    vecs[10] = '{3'b110, 10'd7, 0, 2,  10'd8, 10'd7, 2'b10, 16'd2};
    vecs[11] = '{3'b011, 10'd0, 0, 4,  10'd8, 10'd7, 2'b01, 16'd4};
    vecs[12] = '{3'b100, 10'd7, 0, 3,  10'd8, 10'd7, 2'b01, 16'd3};

    sys_rst_n = 1'b0;
    host_val = 3'b000; host_lk = '0; stage_rdy = 3'b000; stage_done = 3'b000;
    m_lm = 0; m_lk = 10'd0;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    @(negedge clk); sys_rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      episode(vecs[i].req, vecs[i].lk, vecs[i].rdy_dly, vecs[i].run_len, 0);
      check($sformatf("vec%0d_landmark_num", i), landmark_num, vecs[i].exp_lm);
      check($sformatf("vec%0d_l_k", i), l_k, vecs[i].exp_lk);
      check($sformatf("vec%0d_err_code", i), err_code, vecs[i].exp_code);
      check($sformatf("vec%0d_last_cycles", i), last_cycles, vecs[i].exp_cyc);
    end

    // Re-request during the DONE cycle only: must be dropped. Held one more cycle: must be taken.
    episode(3'b001, 10'd0, 0, 2, 1);
    episode(3'b001, 10'd0, 1, 3, 2);

    launch_prd();
`ifdef EKF_SCHED_WDT_EN
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      stage_rdy = 3'b000;
      if (k <= 16) check("wdt_wait", {err_val, busy}, 2'b01);
      else begin
        check("wdt_err_val", err_val, 1);
        check("wdt_err_code", err_code, 2'b11);
        check("wdt_busy", busy, 0);
        check("wdt_no_done", done_stage, 0);
      end
    end
    @(negedge clk);
    check("wdt_host_rdy", host_rdy, 3'b111);
    check("wdt_err_pulse", err_val, 0);
    check("wdt_landmark_num", landmark_num, m_lm);
`else
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      stage_rdy  = 3'b000;
      stage_done = 3'b000;
      if (k <= 40) check("nowdt_wait", {err_val, busy}, 2'b01);
      if (k == 40) stage_done = 3'b001;
      if (k == 41) check("nowdt_done", done_stage, 3'b001);
      if (k == 42) begin
        check("nowdt_last_cycles", last_cycles, 40);
        check("nowdt_busy", busy, 0);
      end
    end
`endif

    // Reset in the middle of RUN.
    launch_prd();
    repeat (3) begin
      @(negedge clk);
      stage_rdy = 3'b000;
    end
    check("pre_reset_busy", busy, 1);
    sys_rst_n = 1'b0;
    #1;
    check_reset_vals("mid_run");
    @(negedge clk);
    sys_rst_n = 1'b1;
    m_lm = 0; m_lk = 10'd0;
    stage_done = 3'b001;
    repeat (3) begin
      @(negedge clk);
      stage_done = 3'b000;
      check("post_reset_idle", {busy, done_stage}, 0);
    end

    for (int e = 0; e < 40; e++) begin
      logic [2:0] r;
      r = 3'($urandom_range(1, 7));
      episode(r, 10'($urandom_range(0, 9)), int'($urandom_range(0, 3)), int'($urandom_range(1, 12)), 0);
      check("rnd_landmark_num", landmark_num, m_lm);
      check("rnd_l_k", l_k, m_lk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
